sd_spi_ctrl: RTL and testbench
==============================

# sd_spi_ctrl

SPI-side sequencer for the bridge's SD card port. It accepts single-block (64-bit) read and write requests over a valid/ready handshake. For each request it serializes the SD command frame on MOSI, samples the card's R1 response, data token, data and busy phases on MISO, and returns data plus a status code. It sits between the bridge FSM and the `pseudo_SD` card model, and owns all MOSI timing.

## Interface
- `RSP_TIMEOUT`, 256: maximum cycles to wait for the first 0 bit of R1, data-response or read start token.
- `WR_GAP`, 8: idle-high MOSI cycles between the end of R1 and the start of the write data token.
- `clk` in 1: single clock. MOSI changes and MISO is sampled on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle, request accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = CMD24 write, 0 = CMD17 read.
- `req_addr` in 32: block address, used as the command argument.
- `req_data` in 64: write payload.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 64: read payload. Zero for writes.
- `rsp_err` out 2: status. 0 OK, 1 R1 ≠ 8'h00, 2 timeout, 3 data-response ≠ 8'b00000101 or read CRC16 mismatch.
- `MOSI` out 1: serial data to the card.
- `MISO` in 1: serial data from the card.

## Operation
- Request fields are latched at acceptance and stay stable for the whole transaction. Inputs may change afterwards.
- Command frame, 48 bits, MSB first: `2'b01`, 6-bit index (17 or 24), 32-bit `req_addr`, CRC7, end bit `1`.
  - CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
- State machine and transitions:
  - IDLE → CMD: on accept.
  - CMD (48 cycles) → RSP_WAIT.
  - RSP_WAIT → RSP: on the first MISO=0. That 0 is bit 7 of R1.
  - RSP (8 bits total): if R1 ≠ 0 → DONE with err 1. Otherwise → WR_GAP for a write, RD_WAIT for a read.
  - WR_GAP (`WR_GAP` cycles, MOSI=1) → WR_TOK.
  - WR_TOK sends 8'hFE, then WR_DATA sends 64 bits, then WR_CRC sends CRC16 of the data, then → DRSP_WAIT.
  - DRSP_WAIT → DRSP on the first MISO=0. DRSP collects 8 bits.
  - If the token is 8'b00000101 → BUSY. Otherwise → DONE with err 3.
  - BUSY → DONE on the first MISO=1 cycle.
  - RD_WAIT: the first MISO=0 is the last bit of start token 8'hFE. The next cycle begins RD_DATA.
  - RD_DATA (64 bits) → RD_CRC (16 bits) → DONE.
  - DONE: `rsp_valid`=1 for one cycle → IDLE.
- CRC16 is CCITT x^16+x^12+x^5+1, init 0, over the 64 data bits, MSB first.
- Each *_WAIT state has its own cycle counter. If it reaches `RSP_WAIT` limit `RSP_TIMEOUT` → DONE with err 2. BUSY is also bounded by `RSP_TIMEOUT`.
- MOSI is 1 in every state except CMD, WR_TOK, WR_DATA and WR_CRC.

## Timing
- Reset values: `req_ready`=1 (asserts in IDLE), `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `MOSI`=1, state IDLE, all counters 0.
- Reset asserted mid-transaction returns to IDLE on the next edge, with MOSI=1 and no `rsp_valid`.
- The first command bit appears on MOSI in the cycle after acceptance.
- `req_ready` is 0 from acceptance through the DONE cycle, and 1 again the cycle after DONE.
- `rsp_data` and `rsp_err` hold their values until the next DONE.
- `req_valid` held high through DONE starts a new transaction. There is a minimum of one IDLE cycle between transactions.
- Read latency = 1 + 48 + RSP-wait + 8 + token-wait + 64 + 16 + 1 cycles.
- Timeout is counted exactly: err 2 is flagged when the wait counter reaches `RSP_TIMEOUT` with MISO still 1 (or still 0 in BUSY).

## Configuration
- `SD_RD_CRC_CHECK_EN`
  - **Defined:** RD_CRC compares the received CRC16 with the computed value. A mismatch gives err 3, and `rsp_data` still carries the received data.
  - **Undefined:** the 16 CRC bits are clocked in and discarded, and read errors can only be 1 or 2. Write CRC16 generation is always present.

## Test plan
- Reset, then a read at addr 0 → MOSI frame 0x51_00000000_55. The card replies R1 0x00 after 3 cycles, then 0xFE, then data 0x0123456789ABCDEF with a correct CRC. Expect `rsp_valid` pulse, `rsp_data`=0x0123456789ABCDEF, `rsp_err`=0.
- Write to addr 0x00001234 with data 0xDEADBEEFCAFEF00D → expect:
  - CMD24 frame with correct CRC7,
  - exactly `WR_GAP` high cycles after R1,
  - 0xFE, the data and CRC16 on MOSI.
  
  The card returns 0x05 and 20 busy cycles. Expect `rsp_err`=0, with `rsp_valid` one cycle after MISO goes high.
- The card never drives MISO low after CMD → `rsp_err`=2 exactly `RSP_TIMEOUT` cycles after the end bit, and `req_ready` returns.
- R1=0x04 → `rsp_err`=1 with no data phase. Data-response 0x0B → `rsp_err`=3.
- With `SD_RD_CRC_CHECK_EN` defined, a read whose CRC has one flipped bit → `rsp_err`=3. With it undefined, the same stimulus → `rsp_err`=0.
- Pull `rst_n` low during WR_DATA → MOSI=1 and `req_ready`=1 on the next edge, and no `rsp_valid`. A following read completes normally.

Source files
------------

// File: rtl/sd_spi_if.sv
// sd_spi_if: request/response bundle between the bridge FSM and sd_spi_ctrl.
interface sd_spi_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [63:0] req_data;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/sd_spi_ctrl.sv
// sd_spi_ctrl: SPI-mode SD sequencer for single 64-bit CMD17/CMD24 blocks.
// Define SD_RD_CRC_CHECK_EN to verify the CRC16 that trails read data.
module sd_spi_ctrl #(
   parameter int RSP_TIMEOUT = 256,
   parameter int WR_GAP      = 8
) (
   input  logic    clk,
   input  logic    rst_n,
   sd_spi_if.slave bus,
   output logic    MOSI,
   input  logic    MISO
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_CMD       = 4'd1;
   localparam logic [3:0] S_RSP_WAIT  = 4'd2;
   localparam logic [3:0] S_RSP       = 4'd3;
   localparam logic [3:0] S_WR_GAP    = 4'd4;
   localparam logic [3:0] S_WR_TOK    = 4'd5;
   localparam logic [3:0] S_WR_DATA   = 4'd6;
   localparam logic [3:0] S_WR_CRC    = 4'd7;
   localparam logic [3:0] S_DRSP_WAIT = 4'd8;
   localparam logic [3:0] S_DRSP      = 4'd9;
   localparam logic [3:0] S_BUSY      = 4'd10;
   localparam logic [3:0] S_RD_WAIT   = 4'd11;
   localparam logic [3:0] S_RD_DATA   = 4'd12;
   localparam logic [3:0] S_RD_CRC    = 4'd13;
   localparam logic [3:0] S_DONE      = 4'd14;

   localparam logic [7:0]  TOKEN    = 8'hFE;
   localparam logic [7:0]  DRSP_OK  = 8'h05;
   localparam logic [15:0] TMO_LAST = 16'(RSP_TIMEOUT - 1);
   localparam logic [5:0]  GAP_LAST = 6'(WR_GAP - 1);

   logic [3:0]  state;
   logic [5:0]  cnt;
   logic [15:0] wcnt;
   logic        wr;
   logic [47:0] cmd_sh;
   logic [63:0] dat;
   logic [15:0] crc;
   logic [7:0]  sh8;
   logic [63:0] rdata;
   logic [1:0]  rerr;
   logic [39:0] cmd_hdr;
   logic [7:0]  sh8_nxt;
   logic [15:0] crc_tx;
   logic [15:0] crc_rx;
   logic        tmo;
   logic        crc_bad;

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   function automatic logic [15:0] crc16_step(
      input logic [15:0] c,
      input logic        b
   );
      return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
   endfunction

   assign cmd_hdr = {2'b01, bus.req_write ? 6'd24 : 6'd17, bus.req_addr};
   assign sh8_nxt = {sh8[6:0], MISO};
   assign crc_tx  = crc16_step(crc, dat[63]);
   assign crc_rx  = crc16_step(crc, MISO);
   assign tmo     = (wcnt == TMO_LAST);

   // Running the CRC over data plus received CRC leaves zero on a match.
`ifdef SD_RD_CRC_CHECK_EN
   assign crc_bad = (crc_rx != 16'h0000);
`else
   assign crc_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         wcnt   <= '0;
         wr     <= 1'b0;
         cmd_sh <= '0;
         dat    <= '0;
         crc    <= '0;
         sh8    <= '0;
         rdata  <= '0;
         rerr   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  wr     <= bus.req_write;
                  cmd_sh <= {cmd_hdr, crc7(cmd_hdr), 1'b1};
                  dat    <= bus.req_write ? bus.req_data : 64'h0;
                  crc    <= '0;
                  cnt    <= '0;
                  state  <= S_CMD;
               end
            end
            S_CMD: begin
               cmd_sh <= {cmd_sh[46:0], 1'b1};
               if (cnt == 6'd47) begin
                  cnt   <= '0;
                  wcnt  <= '0;
                  state <= S_RSP_WAIT;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_RSP_WAIT: begin
               if (!MISO) begin
                  sh8   <= '0;
                  cnt   <= 6'd1;
                  state <= S_RSP;
               end else if (tmo) begin
                  state <= S_DONE;
                  rerr  <= 2'd2;
                  rdata <= '0;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            S_RSP: begin
               sh8 <= sh8_nxt;
               if (cnt != 6'd7) begin
                  cnt <= cnt + 6'd1;
               end else if (sh8_nxt != 8'h00) begin
                  state <= S_DONE;
                  rerr  <= 2'd1;
                  rdata <= '0;
               end else begin
                  cnt   <= '0;
                  wcnt  <= '0;
                  state <= wr ? S_WR_GAP : S_RD_WAIT;
               end
            end
            S_WR_GAP: begin
               cnt <= (cnt == GAP_LAST) ? 6'd0 : cnt + 6'd1;
               if (cnt == GAP_LAST) state <= S_WR_TOK;
            end
            S_WR_TOK: begin
               cnt <= (cnt == 6'd7) ? 6'd0 : cnt + 6'd1;
               if (cnt == 6'd7) state <= S_WR_DATA;
            end
            S_WR_DATA: begin
               dat <= {dat[62:0], 1'b0};
               crc <= crc_tx;
               cnt <= (cnt == 6'd63) ? 6'd0 : cnt + 6'd1;
               if (cnt == 6'd63) state <= S_WR_CRC;
            end
            S_WR_CRC: begin
               crc  <= {crc[14:0], 1'b0};
               wcnt <= '0;
               cnt  <= (cnt == 6'd15) ? 6'd0 : cnt + 6'd1;
               if (cnt == 6'd15) state <= S_DRSP_WAIT;
            end
            S_DRSP_WAIT: begin
               if (!MISO) begin
                  sh8   <= '0;
                  cnt   <= 6'd1;
                  state <= S_DRSP;
               end else if (tmo) begin
                  state <= S_DONE;
                  rerr  <= 2'd2;
                  rdata <= '0;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            S_DRSP: begin
               sh8 <= sh8_nxt;
               if (cnt != 6'd7) begin
                  cnt <= cnt + 6'd1;
               end else if (sh8_nxt != DRSP_OK) begin
                  state <= S_DONE;
                  rerr  <= 2'd3;
                  rdata <= '0;
               end else begin
                  cnt   <= '0;
                  wcnt  <= '0;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (MISO) begin
                  state <= S_DONE;
                  rerr  <= 2'd0;
                  rdata <= '0;
               end else if (tmo) begin
                  state <= S_DONE;
                  rerr  <= 2'd2;
                  rdata <= '0;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            S_RD_WAIT: begin
               if (!MISO) begin
                  cnt   <= '0;
                  crc   <= '0;
                  state <= S_RD_DATA;
               end else if (tmo) begin
                  state <= S_DONE;
                  rerr  <= 2'd2;
                  rdata <= '0;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            S_RD_DATA: begin
               dat <= {dat[62:0], MISO};
               crc <= crc_rx;
               cnt <= (cnt == 6'd63) ? 6'd0 : cnt + 6'd1;
               if (cnt == 6'd63) state <= S_RD_CRC;
            end
            S_RD_CRC: begin
               crc <= crc_rx;
               cnt <= (cnt == 6'd15) ? 6'd0 : cnt + 6'd1;
               if (cnt == 6'd15) begin
                  state <= S_DONE;
                  rerr  <= crc_bad ? 2'd3 : 2'd0;
                  rdata <= dat;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      MOSI = 1'b1;
      case (state)
         S_CMD:     MOSI = cmd_sh[47];
         S_WR_TOK:  MOSI = TOKEN[3'd7 - cnt[2:0]];
         S_WR_DATA: MOSI = dat[63];
         S_WR_CRC:  MOSI = crc[15];
         default:   MOSI = 1'b1;
      endcase
   end

   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_DONE);
   assign bus.rsp_data  = rdata;
   assign bus.rsp_err   = rerr;

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// tb_sd_spi_ctrl: directed and random SD SPI transactions checked every
// cycle against bit streams and timing built from the protocol rules.
`timescale 1ns/1ps
module tb_sd_spi_ctrl;
   localparam int TMO = 256;
   localparam int GAP = 8;
`ifdef SD_RD_CRC_CHECK_EN
   localparam logic [1:0] CRC_ERR = 2'd3;
`else
   localparam logic [1:0] CRC_ERR = 2'd0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic MOSI;
   logic MISO = 1'b1;

   sd_spi_if bus();

   sd_spi_ctrl #(.RSP_TIMEOUT(TMO), .WR_GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit em [1024];
   bit ms [1024];
   int exp_done;
   logic [1:0] exp_err;
   logic [63:0] exp_data;
   int k = 0;
   bit act = 1'b0;
   logic [47:0] cap;

   bit t_wr, t_nor1;
   logic [31:0] t_addr;
   logic [63:0] t_data;
   logic [7:0] t_r1, t_drsp;
   int t_w1, t_w2, t_busy, t_flip, t_abort;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (k=%0d t=%0t)",
                  nm, a, e, k, $time);
      end
   endtask

   // Reference CRCs as polynomial long division.
   function automatic logic [6:0] m_crc7(input logic [39:0] d);
      logic [46:0] r;
      r = {d, 7'h0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [15:0] m_crc16(input logic [71:0] d,
                                           input int n);
      logic [87:0] r;
      r = {d, 16'h0};
      for (int i = n + 15; i >= 16; i--)
         if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h11021;
      return r[15:0];
   endfunction

   task automatic defaults();
      t_wr = 0; t_nor1 = 0; t_addr = '0; t_data = '0;
      t_r1 = 8'h00; t_drsp = 8'h05;
      t_w1 = 0; t_w2 = 0; t_busy = 0; t_flip = -1; t_abort = -1;
   endtask

   // Cycle k = 0 is the acceptance cycle; arrays hold MOSI/MISO per cycle.
   task automatic plan();
      int p;
      logic [47:0] fr;
      logic [15:0] c, fm;
      logic [87:0] blk;
      for (int i = 0; i < 1024; i++) begin
         em[i] = 1'b1;
         ms[i] = 1'b1;
      end
      fr[47:8] = {2'b01, t_wr ? 6'd24 : 6'd17, t_addr};
      fr[7:0] = {m_crc7(fr[47:8]), 1'b1};
      for (int i = 0; i < 48; i++) em[1 + i] = fr[47 - i];
      exp_data = '0;
      c = m_crc16({8'h00, t_data}, 64);
      p = 49 + t_w1;
      if (t_nor1) begin
         exp_done = 48 + TMO + 1;
         exp_err = 2'd2;
      end else begin
         for (int i = 0; i < 8; i++) ms[p + i] = t_r1[7 - i];
         p += 8;
         if (t_r1 != 8'h00) begin
            exp_done = p;
            exp_err = 2'd1;
         end else if (t_wr) begin
            p += GAP;
            blk = {8'hFE, t_data, c};
            for (int i = 0; i < 88; i++) em[p + i] = blk[87 - i];
            p += 88 + t_w2;
            for (int i = 0; i < 8; i++) ms[p + i] = t_drsp[7 - i];
            p += 8;
            if (t_drsp != 8'h05) begin
               exp_done = p;
               exp_err = 2'd3;
            end else begin
               for (int i = 0; i < t_busy; i++) ms[p + i] = 1'b0;
               exp_done = p + t_busy + 1;
               exp_err = 2'd0;
            end
         end else begin
            fm = (t_flip >= 0) ? (16'h1 << t_flip) : 16'h0;
            blk = {8'hFE, t_data, c ^ fm};
            p += t_w2;
            for (int i = 0; i < 88; i++) ms[p + i] = blk[87 - i];
            exp_done = 1 + 48 + t_w1 + 8 + (t_w2 + 8) + 64 + 16;
            exp_data = t_data;
            exp_err = (t_flip >= 0) ? CRC_ERR : 2'd0;
         end
      end
   endtask

   // Card model and per-cycle output comparison.
   always @(negedge clk) begin
      if (act) begin
         if (t_abort >= 0 && k > t_abort) begin
            chk("abort_mosi", 64'(MOSI), 64'd1);
            chk("abort_ready", 64'(bus.req_ready), 64'd1);
            chk("abort_valid", 64'(bus.rsp_valid), 64'd0);
            act = 1'b0;
         end else if (k <= exp_done) begin
            chk("mosi", 64'(MOSI), 64'(em[k]));
            chk("req_ready", 64'(bus.req_ready), 64'(k == 0));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(k == exp_done));
            if (k >= 1 && k <= 48) cap = {cap[46:0], MOSI};
            if (k == exp_done) begin
               chk("rsp_data", bus.rsp_data, exp_data);
               chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
            end
         end else begin
            chk("ready_after", 64'(bus.req_ready), 64'd1);
            chk("valid_after", 64'(bus.rsp_valid), 64'd0);
            chk("data_hold", bus.rsp_data, exp_data);
            chk("err_hold", 64'(bus.rsp_err), 64'(exp_err));
            act = 1'b0;
         end
         MISO = ms[k];
         k++;
      end else begin
         MISO = 1'b1;
      end
   end

   task automatic run();
      plan();
      if (t_abort >= 0) exp_done = 2000;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_write = t_wr;
      bus.req_addr = t_addr;
      bus.req_data = t_data;
      k = 0;
      act = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr = $urandom;
      bus.req_data = {$urandom, $urandom};
      if (t_abort >= 0) begin
         for (int g = 0; k < t_abort && g < 3000; g++) @(posedge clk);
         #1 rst_n = 1'b0;
      end
      for (int g = 0; act && g < 3000; g++) @(posedge clk);
      if (act) begin
         n_cmp++;
         n_bad++;
         $display("FAIL txn_bound: still active at k=%0d", k);
         act = 1'b0;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr = '0;
      bus.req_data = '0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_data", bus.rsp_data, 64'd0);
      chk("rst_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_mosi", 64'(MOSI), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;

      chk("pin_crc7_cmd0", 64'(m_crc7(40'h40_00000000)), 64'h4A);
      chk("pin_crc7_cmd17", 64'(m_crc7(40'h51_00000000)), 64'h2A);
      chk("pin_crc7_cmd8", 64'(m_crc7(40'h48_000001AA)), 64'h43);
      chk("pin_crc16", 64'(m_crc16(72'h31_3233_3435_3637_3839, 72)),
          64'h31C3);

      defaults();
      t_w1 = 3; t_w2 = 2; t_data = 64'h0123456789ABCDEF;
      run();
      chk("rd0_frame", 64'(cap), 64'h51_00000000_55);
      chk("rd0_latency", 64'(exp_done), 64'd150);
      chk("rd0_data", bus.rsp_data, 64'h0123456789ABCDEF);
      chk("rd0_err", 64'(bus.rsp_err), 64'd0);

      defaults();
      t_wr = 1; t_addr = 32'h0000_1234; t_data = 64'hDEADBEEFCAFEF00D;
      t_w1 = 1; t_w2 = 2; t_busy = 20;
      run();
      chk("wr_err", 64'(bus.rsp_err), 64'd0);
      chk("wr_data", bus.rsp_data, 64'd0);

      defaults();
      t_nor1 = 1;
      run();
      chk("tmo_err", 64'(bus.rsp_err), 64'd2);

      defaults();
      t_r1 = 8'h04; t_w1 = 5;
      run();
      chk("r1_err", 64'(bus.rsp_err), 64'd1);

      defaults();
      t_wr = 1; t_addr = 32'h55; t_data = 64'h1; t_drsp = 8'h0B;
      run();
      chk("drsp_err", 64'(bus.rsp_err), 64'd3);

      defaults();
      t_data = 64'h0123456789ABCDEF; t_flip = 5; t_w2 = 1;
      run();
      chk("crcflip_err", 64'(bus.rsp_err), 64'(CRC_ERR));
      chk("crcflip_data", bus.rsp_data, 64'h0123456789ABCDEF);

      defaults();
      t_w1 = TMO - 1; t_addr = 32'h77; t_data = 64'hA5A5_0F0F_1234_8765;
      run();
      chk("w1_edge_err", 64'(bus.rsp_err), 64'd0);

      defaults();
      t_wr = 1; t_addr = 32'h99; t_data = 64'hFFFF_0000_AAAA_5555;
      t_abort = 100;
      run();

      defaults();
      t_addr = 32'h42; t_data = 64'h0BAD_F00D_600D_CAFE; t_w1 = 2; t_w2 = 4;
      run();
      chk("post_abort_data", bus.rsp_data, 64'h0BAD_F00D_600D_CAFE);

      for (int n = 0; n < 25; n++) begin
         defaults();
         t_wr = 1'($urandom);
         t_addr = $urandom;
         t_data = {$urandom, $urandom};
         t_w1 = $urandom_range(0, 20);
         t_w2 = $urandom_range(0, 20);
         t_busy = $urandom_range(0, 30);
         if ($urandom_range(0, 4) == 0) t_r1 = 8'($urandom_range(1, 127));
         if ($urandom_range(0, 4) == 0) begin
            t_drsp = 8'($urandom_range(0, 127));
            if (t_drsp == 8'h05) t_drsp = 8'h0D;
         end
         if ($urandom_range(0, 3) == 0) t_flip = $urandom_range(0, 15);
         run();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
